// File: rtl/tdm_pkg.sv
// Shared constants and state encoding for the TDM receive path.
package tdm_pkg;
    localparam int N_SLOTS = 16;
    localparam int SLOT_W  = 4;

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;
endpackage

// File: rtl/tdm_demux_1x16_slot_decoder.sv
// 1-to-N_SLOTS one-hot write-enable decode; the structural inverse of the mux tree.
module slot_decoder
    import tdm_pkg::*;
(
    input  logic [SLOT_W-1:0]  slot,
    input  logic               en,
    output logic [N_SLOTS-1:0] we
);
    always_comb begin
        we = '0;
        if (en) we[slot] = 1'b1;
    end
endmodule

// File: rtl/tdm_demux_1x16.sv
// Serial-to-parallel TDM demux: steers each valid bit into its slot and
// presents the reassembled word with a one-cycle valid strobe.
module tdm_demux_1x16
    import tdm_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               din,
    input  logic               din_vld,
    input  logic               sync,
    output logic [N_SLOTS-1:0] dout,
    output logic               dout_vld,
    output logic [SLOT_W-1:0]  slot,
    output logic               locked,
    output logic               sync_err
);
    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_SLOTS - 1);

    state_t             state;
    logic [N_SLOTS-1:0] shadow;
    logic [N_SLOTS-1:0] we;
    logic [SLOT_W-1:0]  wr_slot;
    logic               wr_en;
    logic               in_lock;

    assign in_lock = (state == LOCK);
    assign locked  = in_lock;

    // A sync beat always writes slot 0, whether acquiring or re-aligning.
    assign wr_slot = sync ? '0 : slot;
    assign wr_en   = din_vld && (in_lock || sync);

    slot_decoder u_dec (
        .slot (wr_slot),
        .en   (wr_en),
        .we   (we)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= HUNT;
            slot     <= '0;
            shadow   <= '0;
            dout     <= '0;
            dout_vld <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            dout_vld <= 1'b0;
            sync_err <= 1'b0;
            shadow   <= (shadow & ~we) | (we & {N_SLOTS{din}});
            if (din_vld) begin
                case (state)
                    HUNT: begin
                        if (sync) begin
                            state <= LOCK;
                            slot  <= SLOT_W'(1);
                        end
                    end
                    LOCK: begin
                        if (sync) begin
                            // Early sync drops the partial frame and restarts at slot 1.
                            sync_err <= (slot != '0);
                            slot     <= SLOT_W'(1);
                        end else begin
                            slot <= slot + SLOT_W'(1);
                            if (slot == LAST_SLOT) begin
                                dout     <= {din, shadow[N_SLOTS-2:0]};
                                dout_vld <= 1'b1;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_tdm_demux_1x16.sv
// Directed bench for tdm_demux_1x16: driver tasks push expected words and
// strobe cycles; a negedge monitor pops and compares.
module tb_tdm_demux_1x16;
    import tdm_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               din = 1'b0;
    logic               din_vld = 1'b0;
    logic               sync = 1'b0;
    logic [N_SLOTS-1:0] dout;
    logic               dout_vld;
    logic [SLOT_W-1:0]  slot;
    logic               locked;
    logic               sync_err;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [N_SLOTS-1:0] exp_q[$];
    int                 exp_cyc_q[$];
    int                 err_cyc_q[$];

    tdm_demux_1x16 dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .din_vld  (din_vld),
        .sync     (sync),
        .dout     (dout),
        .dout_vld (dout_vld),
        .slot     (slot),
        .locked   (locked),
        .sync_err (sync_err)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, req);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // driver tasks
    task automatic idle(input int n);
        din_vld = 1'b0;
        sync    = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic b, input logic s);
        din     = b;
        din_vld = 1'b1;
        sync    = s;
        @(posedge clk);
        #1;
        din_vld = 1'b0;
        sync    = 1'b0;
    endtask

    task automatic send_frame(input logic [N_SLOTS-1:0] word, input logic first_sync,
                              input int max_gap);
        for (int k = 0; k < N_SLOTS; k++) begin
            if (max_gap > 0) idle($urandom_range(0, max_gap));
            beat(word[k], first_sync && (k == 0));
        end
        exp_q.push_back(word);
        exp_cyc_q.push_back(cyc);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (dout_vld && sync_err) check("vld_err_overlap", 32'd1, 32'd0);
        if (dout_vld) begin
            if (exp_q.size() == 0) begin
                check("unexpected_dout_vld", dout, 32'd0);
                if (dout == '0) check("unexpected_dout_vld_zero", 32'd1, 32'd0);
            end else begin
                check("dout", dout, exp_q.pop_front());
                check("dout_vld_cycle", cyc, exp_cyc_q.pop_front());
            end
        end
        if (sync_err) begin
            if (err_cyc_q.size() == 0) check("unexpected_sync_err", 32'd1, 32'd0);
            else check("sync_err_cycle", cyc, err_cyc_q.pop_front());
        end
    end

    logic [N_SLOTS-1:0] lb_word;
    logic [N_SLOTS-1:0] part_word;

    initial begin
        // reset state
        do_reset(2);
        check("rst_dout", dout, 0);
        check("rst_locked", locked, 0);
        check("rst_slot", slot, 0);
        check("rst_dout_vld", dout_vld, 0);
        check("rst_sync_err", sync_err, 0);

        // basic frame
        send_frame(16'hB4F6, 1'b1, 0);
        idle(2);
        check("basic_locked", locked, 1);
        check("basic_slot", slot, 0);

        // HUNT filtering
        do_reset(1);
        for (int i = 0; i < 5; i++) begin
            beat(1'b1, 1'b0);
            check("hunt_slot", slot, 0);
            check("hunt_locked", locked, 0);
        end
        send_frame(16'h00FF, 1'b1, 0);
        idle(2);

        // gaps plus back-to-back frames, sync only on the first
        send_frame(16'hA5A5, 1'b1, 3);
        send_frame(16'h3C3C, 1'b0, 3);
        idle(3);
        check("gaps_dout_hold", dout, 16'h3C3C);

        // misaligned sync after 7 beats
        part_word = 16'h5A5A;
        for (int k = 0; k < 7; k++) beat(part_word[k], k == 0);
        check("mis_slot", slot, 7);
        beat(1'b0, 1'b1);          // bit 0 of 16'h1234
        err_cyc_q.push_back(cyc);
        check("mis_slot_restart", slot, 1);
        lb_word = 16'h1234;
        for (int k = 1; k < N_SLOTS; k++) beat(lb_word[k], 1'b0);
        exp_q.push_back(lb_word);
        exp_cyc_q.push_back(cyc);
        idle(2);

        // reset mid-frame
        send_frame(16'hFFFF, 1'b0, 0);
        for (int k = 0; k < 10; k++) beat(1'b1, 1'b0);
        do_reset(1);
        check("midrst_dout", dout, 0);
        check("midrst_locked", locked, 0);
        check("midrst_slot", slot, 0);
        send_frame(16'h8001, 1'b1, 0);
        idle(2);

        // loopback through a 16:1 select counter
        lb_word = 16'hB4F6;
        for (int f = 0; f < 3; f++) begin
            for (int s = 0; s < N_SLOTS; s++) beat(lb_word[s], s == 0);
            exp_q.push_back(lb_word);
            exp_cyc_q.push_back(cyc);
        end
        idle(4);

        check("exp_q_drained", exp_q.size(), 0);
        check("err_q_drained", err_cyc_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
